// File: rtl/weight_loader.sv
// Streams DEPTH weight words from a valid/ready input into a weight-memory write port.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds a trailing checksum word and error_o reporting.
module weight_loader #(
  parameter int DEPTH  = 784,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        dbg_state_o
);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [WIDTH-1:0]    wr_data_q;
  logic                load_start;
  logic                load_acc;
  logic                last_word;

  // Handshake: a word transfers on a rising edge where valid_i && ready_o; ready_o
  // is a pure function of the state, so it never depends on valid_i.
  assign load_start = ((state_q == IDLE) || (state_q == DONE)) && start_i;
  assign load_acc   = (state_q == LOAD) && valid_i;
  assign last_word  = (cnt_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        if (valid_i && last_word) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      CHECK: begin
        if (valid_i) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (load_start) begin
        cnt_q <= '0;
      end else if (load_acc) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= cnt_q;
        wr_data_q <= data_i;
        cnt_q     <= cnt_q + 1'b1;
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q;
  logic             error_q;
  logic             check_acc;

  assign check_acc = (state_q == CHECK) && valid_i;

  // Checksum wraps naturally at WIDTH bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (load_start) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (load_acc) begin
      csum_q <= csum_q + data_i;
    end else if (check_acc) begin
      error_q <= (data_i != csum_q);
    end
  end

  assign error_o = error_q;
  assign ready_o = (state_q == LOAD) || (state_q == CHECK);
`else
  assign error_o = 1'b0;
  assign ready_o = (state_q == LOAD);
`endif

  assign busy_o      = ready_o;
  assign done_o      = (state_q == DONE);
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: a DEPTH=4 and a DEPTH=784 instance against a word-list model.
// Honours WEIGHT_LOADER_CHECKSUM_EN the same way as the design.
module tb_weight_loader;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 10;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk, rst_n;
  logic start [2];
  logic valid [2];
  logic [WIDTH-1:0] data [2];
  logic ready [2];
  logic wr_en [2];
  logic [ADDR_W-1:0] wr_addr [2];
  logic [WIDTH-1:0] wr_data [2];
  logic busy [2];
  logic done [2];
  logic error [2];
  logic [1:0] dbg [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W+WIDTH-1:0] exp_q0[$];
  logic [ADDR_W+WIDTH-1:0] exp_q1[$];
  logic [ADDR_W-1:0] last_addr [2];
  logic [WIDTH-1:0]  last_data [2];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  weight_loader #(.DEPTH(4), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]),
    .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]), .dbg_state_o(dbg[0])
  );

  weight_loader #(.DEPTH(784), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_full (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]),
    .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]), .dbg_state_o(dbg[1])
  );

  function automatic int depth_of(input int s);
    return (s == 0) ? 4 : 784;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int q_size(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [ADDR_W+WIDTH-1:0] q_pop(input int s);
    if (s == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void q_push(input int s, input logic [ADDR_W+WIDTH-1:0] v);
    if (s == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endfunction

  task automatic check_idle(input int s, input string tag);
    check_eq($sformatf("%s_ready%0d", tag, s), ready[s], 0);
    check_eq($sformatf("%s_wr_en%0d", tag, s), wr_en[s], 0);
    check_eq($sformatf("%s_wr_addr%0d", tag, s), wr_addr[s], 0);
    check_eq($sformatf("%s_wr_data%0d", tag, s), wr_data[s], 0);
    check_eq($sformatf("%s_busy%0d", tag, s), busy[s], 0);
    check_eq($sformatf("%s_done%0d", tag, s), done[s], 0);
    check_eq($sformatf("%s_error%0d", tag, s), error[s], 0);
  endtask

  // Scoreboard: each accepted weight must appear as a write at the very next
  // negedge; outside writes the address/data outputs must hold.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        if (s == 0) exp_q0.delete(); else exp_q1.delete();
        last_addr[s] = '0;
        last_data[s] = '0;
      end else if (wr_en[s]) begin
        if (q_size(s) == 0) begin
          check_eq($sformatf("spurious_wr%0d", s), wr_en[s], 0);
        end else begin
          logic [ADDR_W+WIDTH-1:0] e;
          e = q_pop(s);
          check_eq($sformatf("wr_addr%0d", s), wr_addr[s], e[ADDR_W+WIDTH-1:WIDTH]);
          check_eq($sformatf("wr_data%0d", s), wr_data[s], e[WIDTH-1:0]);
        end
        last_addr[s] = wr_addr[s];
        last_data[s] = wr_data[s];
      end else begin
        if (q_size(s) != 0) begin
          void'(q_pop(s));
          check_eq($sformatf("missing_wr%0d", s), wr_en[s], 1);
        end
        check_eq($sformatf("hold_addr%0d", s), wr_addr[s], last_addr[s]);
        check_eq($sformatf("hold_data%0d", s), wr_data[s], last_data[s]);
      end
    end
  end

  // ---------------- driver ----------------
  // pat: 0 random, 1 k mod 256, 2 (k+1)*0x11, 3 k+1
  // gap_mode: 0 none, 1 two idle cycles before each word, 2 random 0..2
  task automatic do_load(input int s, input int pat, input int gap_mode,
                         input bit bad_csum, input int start_at);
    int depth, total, n_gap;
    logic [WIDTH-1:0] sum, d;
    bit last;
    depth = depth_of(s);
    total = depth + (CSUM ? 1 : 0);
    sum = '0;
    @(negedge clk);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    check_eq($sformatf("st_busy%0d", s), busy[s], 1);
    check_eq($sformatf("st_ready%0d", s), ready[s], 1);
    check_eq($sformatf("st_done%0d", s), done[s], 0);
    check_eq($sformatf("st_error%0d", s), error[s], 0);
    for (int k = 0; k < total; k++) begin
      n_gap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < n_gap; g++) begin
        valid[s] = 1'b0;
        data[s]  = WIDTH'($urandom_range(0, 255));
        @(negedge clk);
        check_eq($sformatf("gap_ready%0d", s), ready[s], 1);
      end
      if (k < depth) begin
        case (pat)
          0: d = WIDTH'($urandom_range(0, 255));
          1: d = WIDTH'(k % 256);
          2: d = WIDTH'((k + 1) * 8'h11);
          default: d = WIDTH'(k + 1);
        endcase
      end else begin
        d = bad_csum ? sum + 1'b1 : sum;
      end
      valid[s] = 1'b1;
      data[s]  = d;
      if (k == start_at) start[s] = 1'b1;
      @(posedge clk);
      if (k < depth) begin
        q_push(s, {ADDR_W'(k), d});
        sum = sum + d;
      end
      @(negedge clk);
      start[s] = 1'b0;
      last = (k == total - 1);
      check_eq($sformatf("w%0d_busy%0d", k, s), busy[s], !last);
      check_eq($sformatf("w%0d_ready%0d", k, s), ready[s], !last);
      check_eq($sformatf("w%0d_done%0d", k, s), done[s], last);
    end
    valid[s] = 1'b0;
    check_eq($sformatf("end_error%0d", s), error[s], CSUM && bad_csum);
    @(negedge clk);
    check_eq($sformatf("idle_done%0d", s), done[s], 1);
    check_eq($sformatf("idle_busy%0d", s), busy[s], 0);
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid[0] = 1'b1;
      data[0]  = WIDTH'($urandom_range(0, 255));
      @(posedge clk);
      q_push(0, {ADDR_W'(k), data[0]});
      if (k == 0) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1 check_idle(0, "rst_mid");
    check_idle(1, "rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      data[0] = WIDTH'($urandom_range(0, 255));
      @(negedge clk);
      check_eq("post_rst_ready0", ready[0], 0);
      check_eq("post_rst_busy0", busy[0], 0);
    end
    valid[0] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0;
      valid[s] = 1'b0;
      data[s]  = '0;
    end
    #2;
    check_idle(0, "reset");
    check_idle(1, "reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_load(0, 2, 0, 1'b0, -1);
    do_load(0, 3, 0, 1'b0, -1);
    do_load(0, 3, 0, 1'b1, -1);
    do_load(0, 0, 1, 1'b0, -1);
    do_load(0, 0, 0, 1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      do_load(0, 0, 2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)) - 1);
    end
    reset_mid_load();
    do_load(0, 0, 0, 1'b0, -1);

    do_load(1, 1, 0, 1'b0, -1);
    do_load(1, 0, 2, 1'b1, 100);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 784, number of weight words written per load.
REQ-002 SHALL have parameter WIDTH, default 8, weight word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 10, write address width; ADDR_W SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 start_i  input  1  single-cycle pulse that begins a load.
REQ-008 data_i  input  WIDTH  incoming weight word.
REQ-009 valid_i  input  1  data_i is valid.
REQ-010 ready_o  output  1  loader accepts data_i this cycle.
REQ-011 wr_en_o  output  1  write strobe to the weight memory write port.
REQ-012 wr_addr_o  output  ADDR_W  weight memory write address.
REQ-013 wr_data_o  output  WIDTH  weight memory write data.
REQ-014 busy_o  output  1  load in progress.
REQ-015 done_o  output  1  load complete; held until the next start_i.
REQ-016 error_o  output  1  checksum mismatch on the last load; held until the next start_i.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CHECK and DONE; CHECK exists only with WEIGHT_LOADER_CHECKSUM_EN.
REQ-018 IDLE or DONE plus start_i -> LOAD: clear address counter, checksum, done_o and error_o.
REQ-019 start_i in LOAD or CHECK SHALL be ignored.
REQ-020 ready_o SHALL be 1 only in LOAD and CHECK, and SHALL not depend combinationally on valid_i.
REQ-021 A word is accepted when valid_i && ready_o at a rising edge; with valid_i low, nothing changes.
REQ-022 Accepted LOAD word: next cycle wr_en_o=1, wr_addr_o=counter value at acceptance, wr_data_o=data_i; write latency is exactly 1 cycle.
REQ-023 wr_en_o SHALL be 1 for exactly one cycle per accepted LOAD word and 0 otherwise; back-to-back accepts give back-to-back writes.
REQ-024 Address counter increments by 1 per accepted LOAD word; it never wraps within a load.
REQ-025 The accept at address DEPTH-1 SHALL move the FSM to CHECK (macro defined) or DONE (macro undefined) on the same edge.
REQ-026 Checksum is the running sum of accepted LOAD words modulo 2**WIDTH.
REQ-027 In CHECK, the accepted word is compared with the checksum; it produces no write; FSM -> DONE; error_o=1 on mismatch.
REQ-028 busy_o SHALL be 1 in LOAD and CHECK and 0 otherwise.
REQ-029 done_o SHALL be 1 in DONE and 0 otherwise.
REQ-030 wr_addr_o and wr_data_o SHALL hold their last values while wr_en_o=0.

Reset
REQ-031 Reset asserted SHALL immediately force: state IDLE, counter 0, checksum 0, ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, error_o=0.
REQ-032 Reset mid-load SHALL abandon the load with no further writes; a new start_i is required after release.

Configuration
REQ-033 Macro WEIGHT_LOADER_CHECKSUM_EN defined: CHECK state and checksum logic present, and one checksum word follows the DEPTH weights.
REQ-034 Macro WEIGHT_LOADER_CHECKSUM_EN undefined: no CHECK state and no checksum logic; error_o tied 0; DONE entered after DEPTH words.

Verification
REQ-035 DEPTH=4, macro off; start_i, then words 0x11,0x22,0x33,0x44 with valid_i constant 1 -> writes at addresses 0..3, one per cycle, each 1 cycle after its accept; done_o=1 on the edge after the 4th accept; busy_o=0.
REQ-036 DEPTH=4, macro on; words 0x01,0x02,0x03,0x04 then 0x0A -> 4 writes, no 5th write, done_o=1, error_o=0; repeat with final word 0x0B -> error_o=1.
REQ-037 valid_i toggled 1,0,0,1,... during a load -> wr_en_o only after accepts; addresses contiguous; wr_addr_o and wr_data_o stable in gaps.
REQ-038 start_i pulsed at address 2 of a load -> no counter reset; the load completes normally.
REQ-039 rst_ni asserted after 2 accepts -> all outputs 0 immediately; no writes after release until start_i; a new load begins at address 0.
REQ-040 DEPTH=784 full load of a pattern (word k = k mod 256) -> 784 writes at addresses 0..783 with matching data; done_o asserted once; checksum accepted when the macro is on.
